lock_controller: RTL and testbench
==================================

# lock_controller

Synchronous sequencer for the keypad lock datapath. It turns the raw set/enter buttons into single-cycle press events and runs the lock state machine (IDLE / INPUT_PASSWORD / OPENED / SET_AWAITING / ALARM). It owns the stored password, the retry budget and one shared timeout timer for auto-relock, set-mode abort and alarm lockout. It sits between the top-level `ui_in`/`uio_in` pins and the status outputs, and replaces per-signal edge-triggered state logic with one fully clocked FSM.

## Interface

**Parameters**
- `PW_W`, default 7: password and code width.
- `MAX_TRIES`, default 3: wrong entries allowed before ALARM; range 1..3.
- `OPEN_CYCLES`, default 16'd5000: cycles spent in OPENED before auto-relock, and in SET_AWAITING before abort; must be ≥1.
- `LOCKOUT_CYCLES`, default 16'd20000: cycles spent in ALARM; must be ≥1.
- `DEFAULT_PW`, default 7'h00: password value after reset.

**Ports**
- `clk` input, 1: single clock; all logic is on its rising edge.
- `rst` input, 1: reset, synchronous and active-high.
- `set_btn` input, 1: set-password button level, already synchronized to `clk`.
- `enter_btn` input, 1: enter/lock button level, already synchronized to `clk`.
- `code_in` input, PW_W: code or new password, sampled on press events.
- `state` output, 3: current state. Encoding: IDLE 000, SET_AWAITING 001, OPENED 010, ALARM 011, INPUT_PASSWORD 100.
- `unlocked` output, 1: high while in OPENED.
- `alarm` output, 1: high while in ALARM.
- `tries_left` output, 2: remaining wrong attempts.
- `pw_updated` output, 1: one-cycle pulse when the password register is written.

## Operation

**Press detection**
- `set_q` and `enter_q` register the previous button levels. Reset loads both with 1, so a button held through reset gives no event until it is released and pressed again.
- `set_press = set_btn & ~set_q`; `enter_press = enter_btn & ~enter_q`.

**State transitions**
- IDLE:
  - `enter_press` → INPUT_PASSWORD.
  - `set_press` is ignored.
- INPUT_PASSWORD, on `enter_press`:
  - If `code_in == password`: → OPENED, and `tries_left` reloads to MAX_TRIES.
  - Otherwise `tries_left` decrements. If the new value is 0 → ALARM, else → IDLE.
  - `set_press` is ignored in this state. It never writes the password.
- OPENED:
  - `enter_press` → IDLE (manual lock).
  - Else `set_press` → SET_AWAITING.
  - Else timer expiry → IDLE (auto-relock).
  - `enter_press` has priority over `set_press`, which has priority over expiry.
- SET_AWAITING:
  - `enter_press` → IDLE as an abort; the password is not written.
  - Else `set_press`: `password <= code_in`, `pw_updated` pulses, → IDLE.
  - Else timer expiry → IDLE as an abort.
  - `enter_press` has priority over `set_press`.
- ALARM:
  - All presses are ignored.
  - On timer expiry → IDLE, and `tries_left` reloads to MAX_TRIES.
- Unused encodings (101–111) → IDLE on the next edge, with no other side effects.

**Timer**
- One 16-bit counter, cleared on every state change.
- It increments only in OPENED, SET_AWAITING and ALARM.
- Expiry is `timer == LIMIT-1`, so the state lasts exactly LIMIT cycles when no press occurs.
- LIMIT is OPEN_CYCLES in OPENED and SET_AWAITING, and LOCKOUT_CYCLES in ALARM.
- The counter never wraps.

**Arithmetic**
- `tries_left` never decrements below 0 and never exceeds MAX_TRIES.
- The comparison is the full PW_W-bit equality.

## Timing

- All outputs are registered. `unlocked` and `alarm` are decoded from the next state and registered, so they change on the same edge as `state`.
- Reset values: `state` = IDLE, `unlocked` = 0, `alarm` = 0, `tries_left` = MAX_TRIES, `pw_updated` = 0, `password` = DEFAULT_PW, `timer` = 0.
- Latency: a button going high before edge k is a press at edge k. `state` and the other outputs reflect it after edge k, which is 1 cycle of latency.
- `pw_updated` is high for exactly the cycle after the write edge. The new password is in force from that same edge.
- A held button produces exactly one press. Presses on both buttons in the same cycle resolve by the priorities above.
- Reset mid-operation overrides everything, including a same-cycle press:
  - `password` returns to DEFAULT_PW.
  - `tries_left` reloads.
  - An in-progress lockout is cancelled.

## Test plan

- **Reset and default unlock.** Assert `rst` for 2 cycles while holding `enter_btn`=1, then release.
  - Required: `state`=000, `tries_left`=3, no transition.
  - Then press `enter` twice with `code_in`=7'h00. Required: `state` goes 100 then 010, `unlocked`=1 on the same edge as `state`.
- **Password change.** From OPENED, press `set` (→001), set `code_in`=7'h5A, press `set`.
  - Required: `pw_updated` high for 1 cycle, `state`=000.
  - Then an entry with 7'h00 fails and an entry with 7'h5A opens.
- **Lockout.** Make three wrong entries.
  - Required: `tries_left` goes 2, 1, then `state`=011 and `alarm`=1.
  - Presses are ignored for LOCKOUT_CYCLES, then `state`=000 and `tries_left`=3.
  - Repeat with LOCKOUT_CYCLES=1 and check that the state lasts exactly 1 cycle.
- **Auto-relock.** With OPEN_CYCLES=8, open the lock and apply no press.
  - Required: `unlocked` is high for exactly 8 cycles, then `state`=000.
- **Simultaneous and abort cases.**
  - In SET_AWAITING, press `set` and `enter` in the same cycle. Required: password unchanged, no `pw_updated`, `state`=000.
  - In OPENED, press `set` and `enter` in the same cycle. Required: → IDLE.
- **Reset mid-operation.** Assert `rst` during ALARM and during SET_AWAITING.
  - Required: IDLE on the next edge, `password`=DEFAULT_PW, `tries_left`=3, timer cleared.

Source files
------------

// File: rtl/lock_if.sv
// Button inputs and status outputs of the keypad lock sequencer, bundled so the
// pin-level wrapper and the sequencer share one port definition.
interface lock_if #(
  parameter int PW_W = 7
);
  logic            set_btn;
  logic            enter_btn;
  logic [PW_W-1:0] code_in;
  logic [2:0]      state;
  logic            unlocked;
  logic            alarm;
  logic [1:0]      tries_left;
  logic            pw_updated;

  modport master (
    output set_btn, enter_btn, code_in,
    input  state, unlocked, alarm, tries_left, pw_updated
  );

  modport slave (
    input  set_btn, enter_btn, code_in,
    output state, unlocked, alarm, tries_left, pw_updated
  );
endinterface

// File: rtl/lock_controller.sv
// Keypad lock sequencer: button press detection, lock FSM, stored password,
// retry budget and one shared timer for relock / set-abort / alarm lockout.
module lock_controller #(
  parameter int              PW_W           = 7,
  parameter int              MAX_TRIES      = 3,
  parameter logic [15:0]     OPEN_CYCLES    = 16'd5000,
  parameter logic [15:0]     LOCKOUT_CYCLES = 16'd20000,
  parameter logic [PW_W-1:0] DEFAULT_PW     = '0
) (
  input  logic   clk,
  input  logic   rst,
  lock_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_SET   = 3'b001,
    S_OPEN  = 3'b010,
    S_ALARM = 3'b011,
    S_INPUT = 3'b100
  } state_e;

  localparam logic [1:0] MAX_T = 2'(MAX_TRIES);

  state_e          state_q, state_d;
  logic [15:0]     timer_q, timer_d;
  logic [1:0]      tries_q, tries_d;
  logic [PW_W-1:0] pw_q, pw_d;
  logic            pw_upd_q, pw_upd_d;
  logic            unlocked_q, unlocked_d;
  logic            alarm_q, alarm_d;
  logic            set_q, set_d;
  logic            enter_q, enter_d;

  logic            set_press, enter_press;
  logic [15:0]     limit;
  logic            expired;
  logic            timed;

  always_comb begin
    set_d       = bus.set_btn;
    enter_d     = bus.enter_btn;
    set_press   = bus.set_btn & ~set_q;
    enter_press = bus.enter_btn & ~enter_q;

    limit   = (state_q == S_ALARM) ? LOCKOUT_CYCLES : OPEN_CYCLES;
    expired = (timer_q == limit - 16'd1);

    state_d  = state_q;
    tries_d  = tries_q;
    pw_d     = pw_q;
    pw_upd_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enter_press) state_d = S_INPUT;
      end
      S_INPUT: begin
        if (enter_press) begin
          if (bus.code_in == pw_q) begin
            state_d = S_OPEN;
            tries_d = MAX_T;
          end else begin
            tries_d = (tries_q == 2'd0) ? 2'd0 : tries_q - 2'd1;
            state_d = (tries_d == 2'd0) ? S_ALARM : S_IDLE;
          end
        end
      end
      S_OPEN: begin
        if (enter_press)    state_d = S_IDLE;
        else if (set_press) state_d = S_SET;
        else if (expired)   state_d = S_IDLE;
      end
      S_SET: begin
        if (enter_press) begin
          state_d = S_IDLE;
        end else if (set_press) begin
          pw_d     = bus.code_in;
          pw_upd_d = 1'b1;
          state_d  = S_IDLE;
        end else if (expired) begin
          state_d = S_IDLE;
        end
      end
      S_ALARM: begin
        if (expired) begin
          state_d = S_IDLE;
          tries_d = MAX_T;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Timer restarts on any state change and saturates rather than wrapping.
    timed = (state_q == S_OPEN) || (state_q == S_SET) || (state_q == S_ALARM);
    if (state_d != state_q)                 timer_d = 16'd0;
    else if (timed && timer_q != 16'hFFFF)  timer_d = timer_q + 16'd1;
    else                                    timer_d = timer_q;

    unlocked_d = (state_d == S_OPEN);
    alarm_d    = (state_d == S_ALARM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= 16'd0;
      tries_q    <= MAX_T;
      pw_q       <= DEFAULT_PW;
      pw_upd_q   <= 1'b0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
      set_q      <= 1'b1;
      enter_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      tries_q    <= tries_d;
      pw_q       <= pw_d;
      pw_upd_q   <= pw_upd_d;
      unlocked_q <= unlocked_d;
      alarm_q    <= alarm_d;
      set_q      <= set_d;
      enter_q    <= enter_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.unlocked   = unlocked_q;
  assign bus.alarm      = alarm_q;
  assign bus.tries_left = tries_q;
  assign bus.pw_updated = pw_upd_q;

endmodule

// File: tb/tb_lock_controller.sv
// Scoreboard bench: two lock_controller instances (normal and 1-cycle lockout)
// share stimulus; a countdown-based reference model predicts every cycle.
module tb_lock_controller;

  localparam int IDLE = 0, SETW = 1, OPEN = 2, ALRM = 3, INP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edge_cnt = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  lock_if #(.PW_W(7)) ifa ();
  lock_if #(.PW_W(7)) ifb ();

  lock_controller #(.PW_W(7), .MAX_TRIES(3), .OPEN_CYCLES(16'd8),
                    .LOCKOUT_CYCLES(16'd12), .DEFAULT_PW(7'h00))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));

  lock_controller #(.PW_W(7), .MAX_TRIES(3), .OPEN_CYCLES(16'd3),
                    .LOCKOUT_CYCLES(16'd1), .DEFAULT_PW(7'h00))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  typedef struct {
    int         st;
    int         tries;
    logic [6:0] pw;
    bit         upd;
    bit         ps;
    bit         pe;
    int         left;
  } mdl_t;

  typedef struct {
    int tag;
    int st;
    bit unl;
    bit alm;
    int tries;
    bit upd;
  } exp_t;

  mdl_t ma, mb;
  exp_t qa[$];
  exp_t qb[$];

  // Model tracks "cycles remaining" in a timed state rather than an up-counter.
  function automatic mdl_t mstep(mdl_t m, bit r, bit s, bit e, logic [6:0] c,
                                 int open_lim, int lock_lim);
    bit sp, ep;
    if (r) begin
      m.st = IDLE; m.tries = 3; m.pw = 7'h00; m.upd = 0;
      m.ps = 1; m.pe = 1; m.left = 0;
      return m;
    end
    sp = s && !m.ps;
    ep = e && !m.pe;
    m.ps = s; m.pe = e; m.upd = 0;
    case (m.st)
      IDLE: if (ep) m.st = INP;
      INP: if (ep) begin
        if (c == m.pw) begin
          m.st = OPEN; m.left = open_lim; m.tries = 3;
        end else begin
          m.tries = (m.tries > 0) ? m.tries - 1 : 0;
          if (m.tries == 0) begin m.st = ALRM; m.left = lock_lim; end
          else m.st = IDLE;
        end
      end
      OPEN: begin
        if (ep) m.st = IDLE;
        else if (sp) begin m.st = SETW; m.left = open_lim; end
        else begin m.left--; if (m.left == 0) m.st = IDLE; end
      end
      SETW: begin
        if (ep) m.st = IDLE;
        else if (sp) begin m.pw = c; m.upd = 1; m.st = IDLE; end
        else begin m.left--; if (m.left == 0) m.st = IDLE; end
      end
      ALRM: begin
        m.left--;
        if (m.left == 0) begin m.st = IDLE; m.tries = 3; end
      end
      default: m.st = IDLE;
    endcase
    return m;
  endfunction

  function automatic exp_t mk_exp(mdl_t m, int tag);
    exp_t x;
    x.tag = tag; x.st = m.st; x.unl = (m.st == OPEN); x.alm = (m.st == ALRM);
    x.tries = m.tries; x.upd = m.upd;
    return x;
  endfunction

  task automatic step(bit r, bit s, bit e, logic [6:0] c);
    @(posedge clk);
    #1;
    rst = r;
    ifa.set_btn = s; ifa.enter_btn = e; ifa.code_in = c;
    ifb.set_btn = s; ifb.enter_btn = e; ifb.code_in = c;
    ma = mstep(ma, r, s, e, c, 8, 12);
    mb = mstep(mb, r, s, e, c, 3, 1);
    qa.push_back(mk_exp(ma, edge_cnt + 1));
    qb.push_back(mk_exp(mb, edge_cnt + 1));
  endtask

  task automatic press_enter(logic [6:0] c);
    step(0, 0, 1, c);
    step(0, 0, 0, c);
  endtask

  task automatic press_set(logic [6:0] c);
    step(0, 1, 0, c);
    step(0, 0, 0, c);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 7'h00);
  endtask

  task automatic chk(string name, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", name, edge_cnt, got, exp);
    end
  endtask

  // Monitor: compares every DUT output once its predicted edge has passed.
  always @(negedge clk) begin
    exp_t x;
    while (qa.size() > 0 && qa[0].tag <= edge_cnt) begin
      x = qa.pop_front();
      chk("a.state", int'(ifa.state), x.st);
      chk("a.unlocked", int'(ifa.unlocked), int'(x.unl));
      chk("a.alarm", int'(ifa.alarm), int'(x.alm));
      chk("a.tries_left", int'(ifa.tries_left), x.tries);
      chk("a.pw_updated", int'(ifa.pw_updated), int'(x.upd));
    end
    while (qb.size() > 0 && qb[0].tag <= edge_cnt) begin
      x = qb.pop_front();
      chk("b.state", int'(ifb.state), x.st);
      chk("b.unlocked", int'(ifb.unlocked), int'(x.unl));
      chk("b.alarm", int'(ifb.alarm), int'(x.alm));
      chk("b.tries_left", int'(ifb.tries_left), x.tries);
      chk("b.pw_updated", int'(ifb.pw_updated), int'(x.upd));
    end
  end

  initial begin
    bit s_lvl, e_lvl, r;
    logic [6:0] c;
    ifa.set_btn = 0; ifa.enter_btn = 1; ifa.code_in = '0;
    ifb.set_btn = 0; ifb.enter_btn = 1; ifb.code_in = '0;
    ma = mstep(ma, 1, 0, 0, 7'h00, 8, 12);
    mb = mstep(mb, 1, 0, 0, 7'h00, 3, 1);

    // Reset with enter held, then release: no event from the held button.
    step(1, 0, 1, 7'h00);
    step(1, 0, 1, 7'h00);
    step(0, 0, 1, 7'h00);
    step(0, 0, 1, 7'h00);
    step(0, 0, 0, 7'h00);
    // Default-password unlock, then password change to 5A.
    press_enter(7'h00);
    press_enter(7'h00);
    press_set(7'h5A);
    press_set(7'h5A);
    idle(2);
    press_enter(7'h00); press_enter(7'h00);
    press_enter(7'h5A); press_enter(7'h5A);
    press_enter(7'h00);
    // Three wrong entries into lockout, presses ignored while locked out.
    for (int k = 0; k < 3; k++) begin
      press_enter(7'h11); press_enter(7'h11);
    end
    press_enter(7'h5A); press_set(7'h5A);
    idle(12);
    // Auto-relock: open and wait.
    press_enter(7'h5A); press_enter(7'h5A);
    idle(10);
    // Simultaneous set+enter in SET_AWAITING, then in OPENED.
    press_enter(7'h5A); press_enter(7'h5A);
    press_set(7'h33);
    step(0, 1, 1, 7'h33); step(0, 0, 0, 7'h33);
    press_enter(7'h5A); press_enter(7'h5A);
    step(0, 1, 1, 7'h5A); step(0, 0, 0, 7'h5A);
    // Reset during ALARM and during SET_AWAITING.
    for (int k = 0; k < 3; k++) begin
      press_enter(7'h22); press_enter(7'h22);
    end
    step(1, 0, 0, 7'h00); step(0, 0, 0, 7'h00);
    press_enter(7'h00); press_enter(7'h00);
    press_set(7'h44);
    step(1, 1, 0, 7'h44); step(0, 0, 0, 7'h00);
    press_enter(7'h00); press_enter(7'h00);
    idle(10);

    // Randomized phase.
    s_lvl = 0; e_lvl = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) s_lvl = ~s_lvl;
      if ($urandom_range(0, 2) == 0) e_lvl = ~e_lvl;
      case ($urandom_range(0, 3))
        0:       c = ma.pw;
        1:       c = mb.pw;
        2:       c = 7'h5A;
        default: c = 7'($urandom);
      endcase
      r = ($urandom_range(0, 299) == 0);
      step(r, s_lvl, e_lvl, c);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", qa.size() + qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
